// File: rtl/quad_encoder_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | quad_encoder_bank                                                          |
// | Multi-channel 4x quadrature decoder: sync, deglitch, position, velocity.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module quad_encoder_bank #(
  parameter int N_CH       = 2,
  parameter int CNT_W      = 16,
  parameter int FILT_LEN   = 3,
  parameter int WIN_CYCLES = 50000,
  parameter int VEL_W      = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         enc_a,
  input  logic [N_CH-1:0]         enc_b,
  input  logic [N_CH-1:0]         clear,
  input  logic [N_CH-1:0]         err_clr,
  output logic [N_CH*CNT_W-1:0]   position,
  output logic [N_CH*VEL_W-1:0]   velocity,
  output logic                    vel_valid,
  output logic [N_CH-1:0]         dir,
  output logic [N_CH-1:0]         err
);

  localparam int c_win_w     = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  // Accumulator holds +/-WIN_CYCLES plus sign, and is never narrower than the output.
  localparam int c_acc_min_w = $clog2(WIN_CYCLES + 1) + 1;
  localparam int c_acc_w     = (c_acc_min_w > VEL_W) ? c_acc_min_w : VEL_W + 1;

  localparam logic [c_win_w-1:0]        c_win_last = c_win_w'(WIN_CYCLES - 1);
  localparam logic [3:0]                c_filt_len = 4'(FILT_LEN);
  localparam logic signed [c_acc_w-1:0] c_acc_one  = c_acc_w'(1);
  localparam logic signed [c_acc_w-1:0] c_vmax     = c_acc_w'((1 << (VEL_W - 1)) - 1);
  localparam logic signed [c_acc_w-1:0] c_vmin     = ~c_vmax;

  logic [c_win_w-1:0] r_win_cnt;
  logic               r_vel_valid;
  logic               w_win_last;

  assign w_win_last = (r_win_cnt == c_win_last);
  assign vel_valid  = r_vel_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win_cnt   <= '0;
      r_vel_valid <= 1'b0;
    end else begin
      r_win_cnt   <= w_win_last ? '0 : r_win_cnt + 1'b1;
      r_vel_valid <= w_win_last;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0]               r_sync1, r_sync2, r_cand, r_filt, r_ref;
    logic [3:0]               r_fcnt;
    logic                     r_upd, r_primed, r_dir, r_err;
    logic [CNT_W-1:0]         r_pos;
    logic signed [c_acc_w-1:0] r_acc;
    logic [VEL_W-1:0]         r_vel;
    logic [1:0]               w_old_idx, w_new_idx, w_delta;
    logic                     w_cw, w_ccw, w_illegal;
    logic signed [c_acc_w-1:0] w_acc_nxt;
    logic [VEL_W-1:0]         w_vel_nxt;

    // Filter: a candidate differing from the filtered level must persist
    // FILT_LEN cycles beyond its first sample before it is accepted.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_sync1 <= 2'b00;
        r_sync2 <= 2'b00;
        r_cand  <= 2'b00;
        r_fcnt  <= '0;
        r_filt  <= 2'b00;
        r_upd   <= 1'b0;
      end else begin
        r_sync1 <= {enc_a[i], enc_b[i]};
        r_sync2 <= r_sync1;
        r_upd   <= 1'b0;
        if (r_sync2 == r_filt) begin
          r_fcnt <= '0;
        end else if ((r_sync2 != r_cand) || (r_fcnt == '0)) begin
          r_cand <= r_sync2;
          r_fcnt <= 4'd1;
        end else if (r_fcnt == c_filt_len) begin
          r_filt <= r_cand;
          r_fcnt <= '0;
          r_upd  <= 1'b1;
        end else begin
          r_fcnt <= r_fcnt + 4'd1;
        end
      end
    end

    // Gray position of {A,B} along the CW cycle 00,10,11,01.
    assign w_old_idx = {r_ref[0], r_ref[1] ^ r_ref[0]};
    assign w_new_idx = {r_filt[0], r_filt[1] ^ r_filt[0]};
    assign w_delta   = w_new_idx - w_old_idx;
    assign w_cw      = r_upd & r_primed & (w_delta == 2'd1);
    assign w_ccw     = r_upd & r_primed & (w_delta == 2'd3);
    assign w_illegal = r_upd & r_primed & (w_delta == 2'd2);

    always_comb begin
      w_acc_nxt = r_acc;
      if (w_cw) begin
        w_acc_nxt = r_acc + c_acc_one;
      end else if (w_ccw) begin
        w_acc_nxt = r_acc - c_acc_one;
      end
      w_vel_nxt = w_acc_nxt[VEL_W-1:0];
      if (w_acc_nxt > c_vmax) begin
        w_vel_nxt = c_vmax[VEL_W-1:0];
      end else if (w_acc_nxt < c_vmin) begin
        w_vel_nxt = c_vmin[VEL_W-1:0];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_ref    <= 2'b00;
        r_primed <= 1'b0;
        r_pos    <= '0;
        r_acc    <= '0;
        r_vel    <= '0;
        r_dir    <= 1'b0;
        r_err    <= 1'b0;
      end else begin
        if (r_upd) begin
          r_ref    <= r_filt;
          r_primed <= 1'b1;
        end
        if (clear[i]) begin
          r_pos <= '0;
        end else if (w_cw) begin
          r_pos <= r_pos + 1'b1;
        end else if (w_ccw) begin
          r_pos <= r_pos - 1'b1;
        end
        // The window snapshot sees the pre-clear count, so clear only matters mid-window.
        if (w_win_last) begin
          r_vel <= w_vel_nxt;
          r_acc <= '0;
        end else if (clear[i]) begin
          r_acc <= '0;
        end else begin
          r_acc <= w_acc_nxt;
        end
        if (w_cw) begin
          r_dir <= 1'b1;
        end else if (w_ccw) begin
          r_dir <= 1'b0;
        end
        r_err <= (r_err & ~err_clr[i]) | w_illegal;
      end
    end

    assign position[i*CNT_W +: CNT_W] = r_pos;
    assign velocity[i*VEL_W +: VEL_W] = r_vel;
    assign dir[i]                     = r_dir;
    assign err[i]                     = r_err;
  end

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_quad_encoder_bank                                                       |
// | Directed self-checking bench for quad_encoder_bank.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_quad_encoder_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  enc_a, enc_b, clear, err_clr;
  logic [31:0] position;
  logic [7:0]  velocity;
  logic        vel_valid;
  logic [1:0]  dir, err;

  logic        reset_w;
  logic [0:0]  wa, wb, w_clear, w_err_clr;
  logic [15:0] w_pos;
  logic [11:0] w_vel;
  logic        w_vv;
  logic [0:0]  w_dir, w_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n        = 0;

  always #5 clk = ~clk;

  quad_encoder_bank #(
    .N_CH(2), .CNT_W(16), .FILT_LEN(3), .WIN_CYCLES(1000), .VEL_W(4)
  ) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .clear(clear), .err_clr(err_clr), .position(position),
    .velocity(velocity), .vel_valid(vel_valid), .dir(dir), .err(err)
  );

  quad_encoder_bank #(
    .N_CH(1), .CNT_W(16), .FILT_LEN(1), .WIN_CYCLES(50000), .VEL_W(12)
  ) dut_w (
    .clk(clk), .reset(reset_w), .enc_a(wa), .enc_b(wb),
    .clear(w_clear), .err_clr(w_err_clr), .position(w_pos),
    .velocity(w_vel), .vel_valid(w_vv), .dir(w_dir), .err(w_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int t);
    while (n < t) begin
      tick(1);
      n++;
    end
  endtask

  task automatic set_ch(input int ch, input logic [1:0] ab);
    enc_a[ch] = ab[1];
    enc_b[ch] = ab[0];
  endtask

  function automatic logic [1:0] cw_state(input int idx);
    case (idx % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [15:0] pos(input int ch);
    return position[ch*16 +: 16];
  endfunction

  function automatic logic [3:0] vel(input int ch);
    return velocity[ch*4 +: 4];
  endfunction

  task automatic main_seq();
    // Ch0 rested at 11 through reset: primes without counting
    wait_until(20);
    check("prime_pos0", pos(0), 0);
    check("prime_err", err, 0);
    set_ch(0, 2'b01);
    wait_until(26); check("latency_pos0_early", pos(0), 0);
    wait_until(27); check("latency_pos0_first", pos(0), 1);
    check("cw_dir0", dir[0], 1);
    wait_until(30); set_ch(0, 2'b00);
    wait_until(40); set_ch(0, 2'b10);
    wait_until(50); set_ch(0, 2'b11);
    wait_until(70);
    check("cw_pos0", pos(0), 4);
    check("cw_err", err, 0);
    check("cw_dir0_end", dir[0], 1);

    // Short pulses on A are rejected; a 4-cycle pulse counts once each way
    set_ch(0, 2'b01); wait_until(72); set_ch(0, 2'b11);
    wait_until(80); set_ch(0, 2'b01); wait_until(82); set_ch(0, 2'b11);
    wait_until(100); set_ch(0, 2'b01); wait_until(103); set_ch(0, 2'b11);
    wait_until(120);
    check("glitch_pos0", pos(0), 4);
    check("glitch_err", err, 0);
    set_ch(0, 2'b01); wait_until(124); set_ch(0, 2'b11);
    wait_until(127); check("pulse4_pos0", pos(0), 5);
    wait_until(131); check("pulse4_return_pos0", pos(0), 4);
    check("pulse4_return_dir0", dir[0], 0);

    // Ch1: prime on 10, CCW wrap below zero, then illegal jumps
    wait_until(140); set_ch(1, 2'b10);
    wait_until(160);
    check("prime1_pos1", pos(1), 0);
    check("prime1_err", err, 0);
    set_ch(1, 2'b00);
    wait_until(180);
    check("ccw_wrap_pos1", pos(1), 16'hFFFF);
    check("ccw_dir", dir, 2'b00);
    set_ch(1, 2'b11);
    set_ch(0, 2'b00);
    wait_until(200);
    check("illegal_err", err, 2'b11);
    check("illegal_pos1", pos(1), 16'hFFFF);
    check("illegal_pos0", pos(0), 4);
    err_clr = 2'b10;
    wait_until(201); err_clr = 2'b00;
    check("err_clr1_only", err, 2'b01);
    err_clr = 2'b01;
    wait_until(202); err_clr = 2'b00;
    check("err_clr0", err, 2'b00);
    wait_until(210); set_ch(1, 2'b00);
    wait_until(216); err_clr = 2'b10;
    wait_until(217); err_clr = 2'b00;
    check("err_set_wins", err, 2'b10);
    wait_until(218); check("err_sticky", err, 2'b10);
    err_clr = 2'b10;
    wait_until(219); err_clr = 2'b00;
    check("err_clr_again", err, 2'b00);

    // First window: ch0 net +4, ch1 net -1
    wait_until(999);
    check("win1_vv_before", vel_valid, 0);
    check("win1_vel_before", velocity, 0);
    wait_until(1000);
    check("win1_vv", vel_valid, 1);
    check("win1_vel0", vel(0), 4'h4);
    check("win1_vel1", vel(1), 4'hF);
    wait_until(1001); check("win1_vv_pulse", vel_valid, 0);

    // Second window: 20 CW on ch0 (saturates), 5 CCW on ch1
    for (int i = 0; i < 20; i++) begin
      wait_until(1010 + 10 * i);
      set_ch(0, cw_state(i + 1));
      if (i < 5) set_ch(1, cw_state(7 - i));
    end
    wait_until(1220);
    check("vel_pos0", pos(0), 16'd24);
    check("vel_pos1", pos(1), 16'hFFFA);
    check("vel_err", err, 0);
    wait_until(1999);
    check("win2_vv_before", vel_valid, 0);
    check("win2_vel0_hold", vel(0), 4'h4);
    wait_until(2000);
    check("win2_vv", vel_valid, 1);
    check("win2_vel0_sat", vel(0), 4'h7);
    check("win2_vel1", vel(1), 4'hB);
    wait_until(2001); check("win2_vv_pulse", vel_valid, 0);

    // Clear, counted edge and window end all on the edge at n=3000
    wait_until(2100); set_ch(0, 2'b10);
    wait_until(2110); set_ch(0, 2'b11);
    wait_until(2993); set_ch(0, 2'b01);
    wait_until(2999);
    check("coll_pos0_before", pos(0), 16'd26);
    clear = 2'b01;
    wait_until(3000); clear = 2'b00;
    check("coll_pos0", pos(0), 0);
    check("coll_vel0", vel(0), 4'h3);
    check("coll_vel1", vel(1), 4'h0);
    check("coll_vv", vel_valid, 1);
    check("coll_pos1", pos(1), 16'hFFFA);

    // Mid-window clear discards accumulated count
    wait_until(3100); set_ch(0, 2'b00);
    wait_until(3200);
    check("accclr_pos0_pre", pos(0), 1);
    clear = 2'b01;
    wait_until(3201); clear = 2'b00;
    check("accclr_pos0_zero", pos(0), 0);
    wait_until(3300); set_ch(0, 2'b10);
    wait_until(3320); check("accclr_pos0_post", pos(0), 1);
    wait_until(4000);
    check("win4_vel0", vel(0), 4'h1);
    check("win4_vel1", vel(1), 4'h0);
    check("win4_vv", vel_valid, 1);

    // Asynchronous reset mid-run, then priming again
    wait_until(4010); set_ch(1, 2'b10);
    wait_until(4030); check("pre_reset_err", err, 2'b10);
    #3; reset = 1'b1; #1;
    check("areset_pos", position, 0);
    check("areset_vel", velocity, 0);
    check("areset_vv", vel_valid, 0);
    check("areset_dir", dir, 0);
    check("areset_err", err, 0);
    tick(2);
    reset = 1'b0;
    n = 0;
    wait_until(20);
    check("reprime_pos", position, 0);
    check("reprime_err", err, 0);
    set_ch(0, 2'b11);
    wait_until(27);
    check("reprime_pos0", pos(0), 1);
    check("reprime_dir0", dir[0], 1);
    check("reprime_pos1", pos(1), 0);
  endtask

  task automatic wrap_seq();
    tick(4);
    {wa[0], wb[0]} = cw_state(1);
    tick(10);
    check("wrap_prime", w_pos, 0);
    for (int e = 0; e < 32767; e++) begin
      {wa[0], wb[0]} = cw_state(e + 2);
      tick(2);
    end
    tick(6);
    check("wrap_7fff", w_pos, 16'h7FFF);
    {wa[0], wb[0]} = cw_state(32767 + 2);
    tick(6);
    check("wrap_8000", w_pos, 16'h8000);
    {wa[0], wb[0]} = cw_state(32766 + 2);
    tick(6);
    check("wrap_back_7fff", w_pos, 16'h7FFF);
    check("wrap_err", w_err, 0);
  endtask

  initial begin
    reset     = 1'b1;
    reset_w   = 1'b1;
    enc_a     = 2'b01;
    enc_b     = 2'b01;
    clear     = 2'b00;
    err_clr   = 2'b00;
    wa        = 1'b0;
    wb        = 1'b0;
    w_clear   = 1'b0;
    w_err_clr = 1'b0;
    tick(3);
    check("reset_pos", position, 0);
    check("reset_vel", velocity, 0);
    check("reset_vv", vel_valid, 0);
    check("reset_dir", dir, 0);
    check("reset_err", err, 0);
    reset   = 1'b0;
    reset_w = 1'b0;
    fork
      main_seq();
      wrap_seq();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
